// File: rtl/sram_like_axi_bridge.sv
// Merges the core's instruction and data sram-like ports onto one AXI master with a single
// transaction in flight. Optional build macro: SRAM_AXI_ADDR_MAP_EN (kseg0/kseg1 translation).
module sram_like_axi_bridge #(
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1
) (
    input  logic            clk,
    input  logic            rst,
    // instruction sram-like port
    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [31:0]     inst_rdata,
    // data sram-like port
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [31:0]     data_rdata,
    // AXI read address
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    // AXI read data
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AXI write address
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    // AXI write data
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI write response
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [ID_W-1:0] INST_ID_C = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] DATA_ID_C = ID_W'(DATA_ID);

    state_t      state_r;
    state_t      state_nxt_s;

    logic        src_data_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic        aw_done_nxt_s;
    logic        w_done_nxt_s;

    logic        arvalid_r;
    logic        rready_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic        accept_s;
    logic        sel_wr_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        rd_done_s;
    logic        wr_done_s;
    logic        xfer_done_s;
    logic        unused_s;

    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lsb;
            2'd1:    strb = lsb[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        logic [31:0] m;
`ifdef SRAM_AXI_ADDR_MAP_EN
        // kseg0/kseg1 (top bits 2'b10) fold onto physical space
        if (a[31:30] == 2'b10) begin
            m = {3'b000, a[28:0]};
        end else begin
            m = a;
        end
`else
        m = a;
`endif
        return m;
    endfunction

    // Arbitration in IDLE: data wins, and nothing is accepted while in reset
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (!rst && (state_r == IDLE)) begin
            if (data_req) begin
                grant_data_s = 1'b1;
            end else begin
                grant_inst_s = inst_req;
            end
        end else begin
            grant_data_s = 1'b0;
            grant_inst_s = 1'b0;
        end
        accept_s    = grant_data_s | grant_inst_s;
        sel_wr_s    = grant_data_s ? data_wr    : inst_wr;
        sel_size_s  = grant_data_s ? data_size  : inst_size;
        sel_addr_s  = grant_data_s ? data_addr  : inst_addr;
        sel_wdata_s = grant_data_s ? data_wdata : inst_wdata;
    end

    // Next-state logic plus tracking of the two independent write handshakes
    always_comb begin
        state_nxt_s   = state_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = sel_wr_s ? WR : RD_ADDR;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (arvalid_r && arready) begin
                    state_nxt_s = RD_DATA;
                end else begin
                    state_nxt_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rvalid && rlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_DATA;
                end
            end
            WR: begin
                aw_done_nxt_s = aw_done_r | (awvalid_r & awready);
                w_done_nxt_s  = w_done_r  | (wvalid_r & wready);
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    state_nxt_s = WR_RESP;
                end else begin
                    state_nxt_s = WR;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and channel valid/ready flops, all decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            arvalid_r <= (state_nxt_s == RD_ADDR);
            rready_r  <= (state_nxt_s == RD_DATA);
            awvalid_r <= (state_nxt_s == WR) && !aw_done_nxt_s;
            wvalid_r  <= (state_nxt_s == WR) && !w_done_nxt_s;
            bready_r  <= (state_nxt_s == WR_RESP);
        end
    end

    // Request capture at accept time; held stable for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            src_data_r <= 1'b0;
            wr_r       <= 1'b0;
            size_r     <= 2'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
        end else if (accept_s) begin
            src_data_r <= grant_data_s;
            wr_r       <= sel_wr_s;
            size_r     <= sel_size_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            wstrb_r    <= strb_of(sel_size_s, sel_addr_s[1:0]);
        end else begin
            src_data_r <= src_data_r;
            wr_r       <= wr_r;
            size_r     <= size_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
            wstrb_r    <= wstrb_r;
        end
    end

    // Completion is seen directly on the AXI response so data_ok costs no extra cycle
    assign rd_done_s   = (state_r == RD_DATA) && rvalid && rlast;
    assign wr_done_s   = (state_r == WR_RESP) && bvalid;
    assign xfer_done_s = !rst && (rd_done_s || wr_done_s);

    assign inst_addr_ok = grant_inst_s;
    assign data_addr_ok = grant_data_s;
    assign inst_data_ok = xfer_done_s && !src_data_r;
    assign data_data_ok = xfer_done_s &&  src_data_r;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = src_data_r ? DATA_ID_C : INST_ID_C;
    assign araddr  = map_addr(addr_r);
    assign arsize  = {1'b0, size_r};
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = src_data_r ? DATA_ID_C : INST_ID_C;
    assign awaddr  = map_addr(addr_r);
    assign awsize  = {1'b0, size_r};
    assign awvalid = awvalid_r;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid     = src_data_r ? DATA_ID_C : INST_ID_C;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wvalid  = wvalid_r;
    assign wlast   = wvalid_r;
    assign bready  = bready_r;

    // Response IDs/status are irrelevant with a single transaction in flight
    assign unused_s = ^{rid, rresp, bid, bresp, wr_r};

endmodule
